dmem_responder: RTL and testbench
=================================

# dmem_responder

Synthesizable responder for the CPU's data-memory port: the memory end of the `d_mem_addr` / `d_mem_wdata` / `d_mem_wen` / `d_mem_rdata` interface that `cpu_top` drives.
- Provides a word-addressed RAM with true byte-lane writes.
- Provides a small MMIO window with a TOHOST test-status register, a cycle counter and a store counter.
- Ends a test through an explicit pass/fail state machine.
- Sits beside `cpu_top` in simulation tops and FPGA wrappers, replacing ad-hoc behavioural memory models.

## Interface
Parameters:
- DEPTH_WORDS, 1024, RAM depth in 32-bit words.
- MMIO_BASE, 32'hFFFF_0000, base of the MMIO window; only bits [31:16] are decoded.
- TIMEOUT_CYCLES, 100000, watchdog limit in cycles; used only with DMEM_WATCHDOG_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- d_mem_addr  in  32  byte address from the CPU.
- d_mem_wdata  in  32  store data, already lane-aligned by the CPU.
- d_mem_wen  in  4  byte-lane write enables; 0 means read.
- d_mem_rdata  out  32  read data, combinational from address.
- test_done  out  1  test finished.
- test_pass  out  1  test passed; valid when test_done=1.
- fail_code  out  31  failure code; valid when test_done=1 and test_pass=0.
- cycle_count  out  32  cycles spent in RUN.
- store_count  out  32  accepted RAM stores.
- oob_err  out  1  sticky out-of-range access flag.

## Operation
Address decode (exactly one region per access):
- **MMIO:** addr[31:16]==MMIO_BASE[31:16].
- **RAM:** not MMIO and addr[31:2] < DEPTH_WORDS.
- **Out of range:** anything else.

RAM:
- Write at posedge when wen!=0 and rst_n=1. Each lane i with wen[i]=1 writes bits [8i+7:8i]; other lanes are untouched.
- Read is combinational: rdata = mem[addr[31:2]], full word. addr[1:0] is ignored; lane extraction is the CPU's job.
- Array contents are not reset.

Out-of-range access:
- Reads return 0. Writes are dropped.
- Any out-of-range access (read or write) sets oob_err, which stays set until reset.

MMIO offsets (addr[15:0]):
- 0x00 TOHOST, R/W.
- 0x04 CYCLE, R.
- 0x08 STORES, R.
- 0x0C STATUS, R: {29'b0, oob_err, test_pass, test_done}.
- Other offsets read 0. Writes to read-only or undefined offsets are ignored.

MMIO write rules:
- Only full-word writes (wen==4'hF) take effect. Partial-lane MMIO writes are ignored.
- A TOHOST write always updates the readable TOHOST value.

State machine: RUN (reset state), PASS, FAIL; TIMEOUT exists only with DMEM_WATCHDOG_EN.
- RUN, TOHOST write with wdata==1 → PASS.
- RUN, TOHOST write with wdata[0]=1 and wdata!=1 → FAIL, fail_code=wdata[31:1].
- RUN, TOHOST write with wdata[0]=0 → stays in RUN (scratch value only).
- PASS, FAIL and TIMEOUT are terminal until reset. TOHOST writes there update only the readable value.

Counters:
- cycle_count increments every cycle in RUN and saturates at 32'hFFFF_FFFF. It freezes in terminal states.
- store_count increments once per accepted RAM write (any wen!=0, in range) in every state, and saturates.

## Timing
Reset values:
- test_done=0, test_pass=0, fail_code=0, cycle_count=0, store_count=0, oob_err=0, TOHOST=0, state=RUN.
- d_mem_rdata is combinational and not reset.

Cycle behaviour:
- While rst_n=0, RAM and MMIO writes are suppressed. A reset mid-test returns to RUN with counters cleared and RAM intact.
- Read latency is 0 cycles.
- A store at edge N is visible to a read of the same word from cycle N+1. A read-during-write in cycle N returns the old data.
- A TOHOST write sampled at edge N drives test_done/test_pass/fail_code from cycle N+1.
- Counters reflect edge N's event from cycle N+1. A CYCLE read returns the pre-increment value.

## Configuration
DMEM_WATCHDOG_EN:
- **Defined:** when cycle_count reaches TIMEOUT_CYCLES in RUN, the next state is TIMEOUT, with test_done=1, test_pass=0, fail_code=31'h7FFF_FFFF. A TOHOST write on the same edge wins.
- **Undefined:** no TIMEOUT state exists and TIMEOUT_CYCLES is unused.

## Structure
- Package dmem_pkg holds the state enum (RUN/PASS/FAIL/TIMEOUT), the MMIO offset constants, STATUS bit positions and the timeout fail code constant.
- One sub-module, dmem_byte_ram, holds the DEPTH_WORDS×32 array: 4-lane write enable, asynchronous read.
- Decode, MMIO registers, counters and the FSM live in dmem_responder.

## Test plan
- **Byte lanes:** store 32'hAABBCCDD with wen=4'hF to 0x100, then 32'h11223344 with wen=4'b0101 → read 0x100 = 32'hAA22CC44; store_count=2.
- **Pass:** TOHOST write 1 with wen=4'hF at cycle 50 → test_done=1, test_pass=1 next cycle; cycle_count holds 50; STATUS read = 3.
- **Fail and terminal:** TOHOST write 32'h0000_0007 → FAIL, fail_code=3. A later write of 1 leaves test_pass=0, and TOHOST reads 1.
- **Ignored MMIO writes:** TOHOST write with wen=4'b0011, then TOHOST write 2 → still RUN, test_done=0. TOHOST reads 2.
- **Out of range:** read 0x0001_0000 with DEPTH_WORDS=1024 → rdata=0, oob_err=1. A store there leaves store_count unchanged.
- **Watchdog (macro on) and reset:** with TIMEOUT_CYCLES=20 and no TOHOST write → fail_code=31'h7FFF_FFFF after the 20th RUN cycle. Pulse rst_n low 1 cycle → all outputs at reset values, earlier RAM data still readable.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared constants for the data-memory responder: FSM state
//            encodings, MMIO register offsets, STATUS bit positions, the
//            watchdog fail code and a saturating-increment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // Test-status state machine encodings
   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_PASS    = 2'd1;
   localparam logic [1:0] ST_FAIL    = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   // MMIO register offsets (addr[15:0])
   localparam logic [15:0] OFF_TOHOST = 16'h0000;
   localparam logic [15:0] OFF_CYCLE  = 16'h0004;
   localparam logic [15:0] OFF_STORES = 16'h0008;
   localparam logic [15:0] OFF_STATUS = 16'h000C;

   // STATUS register bit positions
   localparam int STATUS_DONE_BIT = 0;
   localparam int STATUS_PASS_BIT = 1;
   localparam int STATUS_OOB_BIT  = 2;

   // fail_code reported when the watchdog ends the test
   localparam logic [30:0] TIMEOUT_FAIL_CODE = 31'h7FFF_FFFF;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_byte_ram
// Purpose  : DEPTH_WORDS x 32 RAM with four independent byte-lane write
//            enables and an asynchronous (combinational) read port.
//            Contents are not reset.
// Ports    : clk   - clock
//            we    - per-byte-lane write enables, sampled at posedge
//            addr  - word index shared by read and write
//            wdata - write data, lane i occupies bits [8i+7:8i]
//            rdata - full word at addr, combinational
// Revision : 1.0 - initial release
// ============================================================================
module dmem_byte_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read sees the pre-edge contents, so a read-during-write returns old data
   assign rdata = mem_q[addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Memory end of the CPU data port. Decodes each access into RAM,
//            MMIO or out-of-range; hosts the TOHOST/CYCLE/STORES/STATUS
//            registers, the run/store counters and the pass/fail FSM.
//            Optional feature macro: DMEM_WATCHDOG_EN (adds a TIMEOUT state
//            entered when cycle_count reaches TIMEOUT_CYCLES in RUN).
// Ports    : clk, rst_n (sync, active-low)
//            d_mem_addr/d_mem_wdata/d_mem_wen - CPU request, wen==0 is read
//            d_mem_rdata  - combinational read data
//            test_done/test_pass/fail_code - test outcome
//            cycle_count/store_count - RUN cycles / accepted RAM stores
//            oob_err      - sticky out-of-range access flag
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS    = 1024,
   parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] d_mem_addr,
   input  logic [31:0] d_mem_wdata,
   input  logic [3:0]  d_mem_wen,
   output logic [31:0] d_mem_rdata,
   output logic        test_done,
   output logic        test_pass,
   output logic [30:0] fail_code,
   output logic [31:0] cycle_count,
   output logic [31:0] store_count,
   output logic        oob_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [1:0]  state_q, state_d;
   logic [31:0] tohost_q, tohost_d;
   logic [30:0] fail_code_q, fail_code_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic [31:0] store_count_q, store_count_d;
   logic        oob_q, oob_d;

   logic        is_mmio, is_ram, is_oob;
   logic        ram_store, tohost_wr;
   logic [3:0]  ram_we;
   logic [31:0] ram_rdata, mmio_rdata, status_word;

   // ---- address decode: exactly one region per access ----
   assign is_mmio = (d_mem_addr[31:16] == MMIO_BASE[31:16]);
   assign is_ram  = !is_mmio && ({2'b00, d_mem_addr[31:2]} < DEPTH_WORDS);
   assign is_oob  = !is_mmio && !is_ram;

   // Writes are held off during reset so a mid-test reset leaves RAM intact
   assign ram_we    = (rst_n && is_ram) ? d_mem_wen : 4'h0;
   assign ram_store = (ram_we != 4'h0);
   // Partial-lane MMIO writes are ignored
   assign tohost_wr = is_mmio && (d_mem_addr[15:0] == OFF_TOHOST) &&
                      (d_mem_wen == 4'hF);

   dmem_byte_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (d_mem_addr[AW+1:2]),
      .wdata (d_mem_wdata),
      .rdata (ram_rdata)
   );

   // ---- read path ----
   always_comb begin
      status_word                  = 32'h0;
      status_word[STATUS_DONE_BIT] = test_done;
      status_word[STATUS_PASS_BIT] = test_pass;
      status_word[STATUS_OOB_BIT]  = oob_q;
   end

   always_comb begin
      case (d_mem_addr[15:0])
         OFF_TOHOST: mmio_rdata = tohost_q;
         OFF_CYCLE:  mmio_rdata = cycle_count_q;
         OFF_STORES: mmio_rdata = store_count_q;
         OFF_STATUS: mmio_rdata = status_word;
         default:    mmio_rdata = 32'h0;
      endcase
   end

   always_comb begin
      if (is_mmio)     d_mem_rdata = mmio_rdata;
      else if (is_ram) d_mem_rdata = ram_rdata;
      else             d_mem_rdata = 32'h0;
   end

   // ---- next-state logic ----
   always_comb begin
      state_d       = state_q;
      tohost_d      = tohost_q;
      fail_code_d   = fail_code_q;
      cycle_count_d = cycle_count_q;
      store_count_d = store_count_q;
      oob_d         = oob_q || is_oob;

      if (tohost_wr) tohost_d = d_mem_wdata;
      if (ram_store) store_count_d = sat_inc(store_count_q);

      if (state_q == ST_RUN) begin
         cycle_count_d = sat_inc(cycle_count_q);
         if (tohost_wr && d_mem_wdata[0]) begin
            if (d_mem_wdata == 32'd1) begin
               state_d = ST_PASS;
            end else begin
               state_d     = ST_FAIL;
               fail_code_d = d_mem_wdata[31:1];
            end
         end
`ifdef DMEM_WATCHDOG_EN
         // Any TOHOST write on the same edge takes priority over the timeout
         else if (!tohost_wr && (cycle_count_d >= TIMEOUT_CYCLES)) begin
            state_d     = ST_TIMEOUT;
            fail_code_d = TIMEOUT_FAIL_CODE;
         end
`endif
      end
   end

`ifndef DMEM_WATCHDOG_EN
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         tohost_q      <= 32'h0;
         fail_code_q   <= 31'h0;
         cycle_count_q <= 32'h0;
         store_count_q <= 32'h0;
         oob_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         tohost_q      <= tohost_d;
         fail_code_q   <= fail_code_d;
         cycle_count_q <= cycle_count_d;
         store_count_q <= store_count_d;
         oob_q         <= oob_d;
      end
   end

   assign test_done   = (state_q != ST_RUN);
   assign test_pass   = (state_q == ST_PASS);
   assign fail_code   = fail_code_q;
   assign cycle_count = cycle_count_q;
   assign store_count = store_count_q;
   assign oob_err     = oob_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. The stimulus thread
//            pushes expected observations into a scoreboard queue for the
//            current cycle; a monitor on the falling edge pops and compares
//            them against the live DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   localparam logic [31:0] MB     = 32'hFFFF_0000;
   localparam logic [31:0] A_TOH  = MB + 32'h0;
   localparam logic [31:0] A_CYC  = MB + 32'h4;
   localparam logic [31:0] A_STO  = MB + 32'h8;
   localparam logic [31:0] A_STAT = MB + 32'hC;

   localparam int K_RDATA = 0, K_DONE = 1, K_PASS = 2, K_FCODE = 3,
                  K_CYC = 4, K_STO = 5, K_OOB = 6;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } item_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] d_mem_addr, d_mem_wdata, d_mem_rdata;
   logic [3:0]  d_mem_wen;
   logic        test_done, test_pass, oob_err;
   logic [30:0] fail_code;
   logic [31:0] cycle_count, store_count;

   item_t sb_q[$];
   logic  obs_valid = 1'b0;
   int    n_checks  = 0;
   int    n_fail    = 0;
   logic  exp_run   = 1'b0;
   int    exp_cycles = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS    (1024),
      .MMIO_BASE      (32'hFFFF_0000),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .d_mem_addr  (d_mem_addr),
      .d_mem_wdata (d_mem_wdata),
      .d_mem_wen   (d_mem_wen),
      .d_mem_rdata (d_mem_rdata),
      .test_done   (test_done),
      .test_pass   (test_pass),
      .fail_code   (fail_code),
      .cycle_count (cycle_count),
      .store_count (store_count),
      .oob_err     (oob_err)
   );

   // ---- monitor ----
   always @(negedge clk) begin
      if (obs_valid) begin
         while (sb_q.size() > 0) begin
            item_t       it;
            logic [31:0] act;
            it = sb_q.pop_front();
            case (it.kind)
               K_RDATA: act = d_mem_rdata;
               K_DONE:  act = {31'b0, test_done};
               K_PASS:  act = {31'b0, test_pass};
               K_FCODE: act = {1'b0, fail_code};
               K_CYC:   act = cycle_count;
               K_STO:   act = store_count;
               default: act = {31'b0, oob_err};
            endcase
            n_checks++;
            if (act !== it.exp) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
         end
      end
   end

   // ---- stimulus helpers ----
   task automatic drive(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w);
      d_mem_addr  = a;
      d_mem_wdata = d;
      d_mem_wen   = w;
   endtask

   task automatic chk(input int kind, input logic [31:0] exp, input string name);
      sb_q.push_back('{kind, exp, name});
      obs_valid = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      if (exp_run && rst_n) exp_cycles++;
      #1;
      obs_valid   = 1'b0;
      d_mem_addr  = 32'h0;
      d_mem_wdata = 32'h0;
      d_mem_wen   = 4'h0;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      step();
      rst_n      = 1'b1;
      exp_run    = 1'b1;
      exp_cycles = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL tb_timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      drive(32'h0, 32'h0, 4'h0);
      @(posedge clk); #1;

      // Store during reset must be suppressed
      drive(32'h200, 32'hCAFE_F00D, 4'hF);
      step();
      step();
      chk(K_DONE, 0, "rst_done");   chk(K_PASS, 0, "rst_pass");
      chk(K_FCODE, 0, "rst_fcode"); chk(K_CYC, 0, "rst_cycles");
      chk(K_STO, 0, "rst_stores");  chk(K_OOB, 0, "rst_oob");
      step();

      rst_n = 1'b1; exp_run = 1'b1; exp_cycles = 0;
      drive(A_STAT, 0, 4'h0);
      chk(K_RDATA, 0, "status_after_reset"); chk(K_CYC, 0, "cycles_start");
      step();

      // Byte lanes
      drive(32'h100, 32'hAABB_CCDD, 4'hF); step();
      drive(32'h100, 32'h1122_3344, 4'b0101);
      chk(K_RDATA, 32'hAABB_CCDD, "read_during_write_old");
      chk(K_STO, 1, "stores_after_1");
      step();
      drive(32'h100, 0, 4'h0);
      chk(K_RDATA, 32'hAA22_CC44, "byte_lane_merge"); chk(K_STO, 2, "stores_after_2");
      step();
      drive(32'h103, 0, 4'h0);
      chk(K_RDATA, 32'hAA22_CC44, "low_addr_bits_ignored");
      step();

      // Top word of RAM
      drive(32'hFFC, 32'h5A5A_A5A5, 4'hF); step();
      drive(32'hFFC, 0, 4'h0);
      chk(K_RDATA, 32'h5A5A_A5A5, "last_word"); chk(K_STO, 3, "stores_after_3");
      chk(K_OOB, 0, "no_oob_yet");
      step();

      // Ignored MMIO writes
      drive(A_TOH, 32'd1, 4'b0011); step();
      drive(A_TOH, 32'd2, 4'hF); chk(K_DONE, 0, "partial_tohost_ignored"); step();
      drive(A_TOH, 0, 4'h0);
      chk(K_RDATA, 32'd2, "tohost_scratch"); chk(K_DONE, 0, "scratch_keeps_run");
      step();
      drive(A_CYC, 32'h1234, 4'hF); step();
      drive(A_CYC, 0, 4'h0);
      chk(K_RDATA, exp_cycles, "cycle_reg_read"); chk(K_CYC, exp_cycles, "cycle_out");
      step();
      drive(A_STO, 0, 4'h0); chk(K_RDATA, 3, "stores_reg_read"); step();

      // Pass on the 50th RUN cycle
      while (exp_cycles < 49) step();
      drive(A_TOH, 32'd1, 4'hF); chk(K_CYC, 49, "cycles_before_pass");
      step();
      exp_run = 1'b0;
      drive(A_STAT, 0, 4'h0);
      chk(K_DONE, 1, "pass_done"); chk(K_PASS, 1, "pass_pass");
      chk(K_RDATA, 3, "pass_status"); chk(K_CYC, 50, "pass_cycles");
      step();
      step(); step();
      chk(K_CYC, 50, "cycles_frozen"); step();
      drive(32'h104, 32'h0BAD_F00D, 4'hF); step();
      drive(A_STO, 0, 4'h0);
      chk(K_RDATA, 4, "store_in_pass_reg"); chk(K_STO, 4, "store_in_pass");
      step();

      // Mid-test reset: counters clear, RAM survives
      reset_pulse();
      drive(32'h100, 0, 4'h0);
      chk(K_DONE, 0, "rst2_done"); chk(K_PASS, 0, "rst2_pass");
      chk(K_FCODE, 0, "rst2_fcode"); chk(K_CYC, 0, "rst2_cycles");
      chk(K_STO, 0, "rst2_stores"); chk(K_OOB, 0, "rst2_oob");
      chk(K_RDATA, 32'hAA22_CC44, "ram_survives_reset");
      step();
      drive(A_TOH, 0, 4'h0); chk(K_RDATA, 0, "tohost_reset"); step();

      // Fail and terminal
      drive(A_TOH, 32'h0000_0007, 4'hF); step();
      exp_run = 1'b0;
      drive(A_TOH, 32'd1, 4'hF);
      chk(K_DONE, 1, "fail_done"); chk(K_PASS, 0, "fail_pass"); chk(K_FCODE, 3, "fail_code");
      step();
      drive(A_TOH, 0, 4'h0);
      chk(K_RDATA, 1, "tohost_after_terminal"); chk(K_PASS, 0, "fail_is_terminal");
      chk(K_FCODE, 3, "fail_code_held"); chk(K_CYC, 3, "fail_cycles_frozen");
      step();

      // Out of range
      drive(32'h0001_0000, 0, 4'h0);
      chk(K_RDATA, 0, "oob_read_zero"); chk(K_OOB, 0, "oob_not_yet");
      step();
      drive(A_STAT, 0, 4'h0);
      chk(K_OOB, 1, "oob_set"); chk(K_RDATA, 5, "status_fail_oob");
      step();
      drive(32'h0001_0000, 32'h1234_5678, 4'hF); step();
      drive(32'h1000, 0, 4'h0);
      chk(K_RDATA, 0, "first_oob_word"); chk(K_STO, 0, "oob_store_dropped");
      step();
      drive(MB + 32'h10, 0, 4'h0); chk(K_RDATA, 0, "undefined_mmio"); step();
      drive(32'h108, 32'h1357_9BDF, 4'hF); step();
      drive(32'h108, 0, 4'h0);
      chk(K_RDATA, 32'h1357_9BDF, "store_in_fail_data"); chk(K_STO, 1, "store_in_fail");
      chk(K_OOB, 1, "oob_sticky");
      step();

      // Watchdog
      reset_pulse();
      chk(K_DONE, 0, "rst3_done"); chk(K_OOB, 0, "rst3_oob");
      step();
`ifdef DMEM_WATCHDOG_EN
      while (exp_cycles < 19) step();
      chk(K_DONE, 0, "before_timeout"); chk(K_CYC, 19, "cycles_before_timeout");
      step();
      exp_run = 1'b0;
      chk(K_DONE, 1, "timeout_done"); chk(K_PASS, 0, "timeout_pass");
      chk(K_FCODE, 32'h7FFF_FFFF, "timeout_code"); chk(K_CYC, 20, "timeout_cycles");
      step();
      step();
      chk(K_CYC, 20, "timeout_frozen"); step();
`else
      while (exp_cycles < 25) step();
      chk(K_DONE, 0, "no_watchdog"); chk(K_CYC, 25, "cycles_no_watchdog");
      step();
`endif

      // Final reset
      reset_pulse();
      drive(32'hFFC, 0, 4'h0);
      chk(K_RDATA, 32'h5A5A_A5A5, "ram_after_final_reset");
      chk(K_DONE, 0, "rst4_done"); chk(K_FCODE, 0, "rst4_fcode");
      chk(K_CYC, 0, "rst4_cycles"); chk(K_STO, 0, "rst4_stores"); chk(K_OOB, 0, "rst4_oob");
      step();
      step();

      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
